bcd_rtc_clock: RTL and testbench

- Parametrised BCD time-of-day counter: HH:MM:SS.
- Has an internal prescaler, a 12/24-hour display mode, a validated time-load port, a daily HH:MM alarm, and rollover strobes.
- Sits between the board oscillator and the seven-segment display driver / LED logic in the example designs.

---
 rtl/bcd_rtc_pkg.sv | 42 ++++
 rtl/bcd_rtc_clock_digit.sv | 38 +++
 rtl/bcd_rtc_clock.sv | 209 ++++++++++++++++++++
 tb/tb_bcd_rtc_clock.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_rtc_pkg.sv
// Shared types, digit limits and time validation for the BCD real-time clock.
package bcd_rtc_pkg;

  typedef logic [3:0] bcd_t;

  // Time of day in 24-hour BCD, laid out as {hh,hl,mh,ml,sh,sl}.
  typedef struct packed {
    bcd_t hh;
    bcd_t hl;
    bcd_t mh;
    bcd_t ml;
    bcd_t sh;
    bcd_t sl;
  } time_t;

  // Alarm HH:MM in 24-hour BCD, laid out as {hh,hl,mh,ml}.
  typedef struct packed {
    bcd_t hh;
    bcd_t hl;
    bcd_t mh;
    bcd_t ml;
  } alarm_t;

  localparam bcd_t DIGIT_MAX_5 = 4'd5;
  localparam bcd_t DIGIT_MAX_9 = 4'd9;
  localparam bcd_t HOUR_MAX_HI = 4'd2;  // hour 23, tens digit
  localparam bcd_t HOUR_MAX_LO = 4'd3;  // hour 23, units digit

  // Digit-wise range check of a time value to be loaded.
  function automatic logic bcd_time_valid(input time_t t);
    logic ok_s;
    ok_s = (t.hh <= HOUR_MAX_HI) &&
           (t.hl <= DIGIT_MAX_9) &&
           !((t.hh == HOUR_MAX_HI) && (t.hl > HOUR_MAX_LO)) &&
           (t.mh <= DIGIT_MAX_5) &&
           (t.ml <= DIGIT_MAX_9) &&
           (t.sh <= DIGIT_MAX_5) &&
           (t.sl <= DIGIT_MAX_9);
    return ok_s;
  endfunction

endpackage

// File: rtl/bcd_rtc_clock_digit.sv
// Single BCD digit counter 0..MAX with load, clear and carry-out.
module bcd_digit_counter
  import bcd_rtc_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  output bcd_t value_o,
  output logic carry_o
);

  bcd_t value_r;

  // Digit register: load beats clear, clear beats increment; wraps MAX -> 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_r <= 4'd0;
    end else if (load_i) begin
      value_r <= load_val_i;
    end else if (clr_i) begin
      value_r <= 4'd0;
    end else if (inc_i) begin
      value_r <= (value_r == bcd_t'(MAX)) ? 4'd0 : (value_r + 4'd1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value_o = value_r;
  // Carry fires when this increment rolls the digit over.
  assign carry_o = inc_i & (value_r == bcd_t'(MAX));

endmodule

// File: rtl/bcd_rtc_clock.sv
// BCD HH:MM:SS time-of-day counter with prescaler, 12/24h display,
// validated time load, daily HH:MM alarm and rollover strobes.
module bcd_rtc_clock
  import bcd_rtc_pkg::*;
#(
  parameter int CLK_DIV   = 32768,
  parameter bit HAS_ALARM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        mode12_i,
  input  logic        set_valid_i,
  input  logic [23:0] set_time_i,
  output logic        set_err_o,
  input  logic        alarm_set_i,
  input  logic [15:0] alarm_time_i,
  input  logic        alarm_en_i,
  output logic        alarm_o,
  output logic        tick_o,
  output logic        day_wrap_o,
  output logic        pm_o,
  output logic [3:0]  hours_high_o,
  output logic [3:0]  hours_low_o,
  output logic [3:0]  minutes_high_o,
  output logic [3:0]  minutes_low_o,
  output logic [3:0]  seconds_high_o,
  output logic [3:0]  seconds_low_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_r;
  time_t         set_time_s;
  logic          set_ok_s;
  logic          load_ok_s;
  logic          load_bad_s;
  logic          tick_s;
  logic          adv_s;

  bcd_t sl_s, sh_s, ml_s, mh_s;
  logic c_sl_s, c_sh_s, c_ml_s, c_mh_s;

  bcd_t   hh_r, hl_r;
  bcd_t   hh_nx_s, hl_nx_s, mh_nx_s, ml_nx_s;
  logic   hour_wrap_s;
  alarm_t next_hm_s;

  bcd_t disp_hh_s, disp_hl_s;
  logic pm_s;

  assign set_time_s = time_t'(set_time_i);
  assign set_ok_s   = bcd_time_valid(set_time_s);
  assign load_ok_s  = set_valid_i & set_ok_s;
  assign load_bad_s = set_valid_i & ~set_ok_s;
  assign tick_s     = en_i & (presc_r == PRESC_LAST);
  // A valid load swallows a coincident tick.
  assign adv_s      = tick_s & ~load_ok_s;

  // Prescaler: restarts on a valid load, wraps on the tick, holds when disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_r <= '0;
    end else if (load_ok_s) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else if (en_i) begin
      presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      presc_r <= presc_r;
    end
  end

  bcd_digit_counter #(.MAX(9)) u_sl (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(adv_s), .clr_i(1'b0),
    .load_i(load_ok_s), .load_val_i(set_time_s.sl), .value_o(sl_s), .carry_o(c_sl_s)
  );
  bcd_digit_counter #(.MAX(5)) u_sh (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(c_sl_s), .clr_i(1'b0),
    .load_i(load_ok_s), .load_val_i(set_time_s.sh), .value_o(sh_s), .carry_o(c_sh_s)
  );
  bcd_digit_counter #(.MAX(9)) u_ml (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(c_sh_s), .clr_i(1'b0),
    .load_i(load_ok_s), .load_val_i(set_time_s.ml), .value_o(ml_s), .carry_o(c_ml_s)
  );
  bcd_digit_counter #(.MAX(5)) u_mh (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(c_ml_s), .clr_i(1'b0),
    .load_i(load_ok_s), .load_val_i(set_time_s.mh), .value_o(mh_s), .carry_o(c_mh_s)
  );

  // Next hour pair: 09->10, 19->20, 23->00 on a minute-tens carry.
  always_comb begin
    hh_nx_s     = hh_r;
    hl_nx_s     = hl_r;
    hour_wrap_s = 1'b0;
    if (c_mh_s) begin
      if ((hh_r == HOUR_MAX_HI) && (hl_r == HOUR_MAX_LO)) begin
        hh_nx_s     = 4'd0;
        hl_nx_s     = 4'd0;
        hour_wrap_s = 1'b1;
      end else if (hl_r == DIGIT_MAX_9) begin
        hh_nx_s = hh_r + 4'd1;
        hl_nx_s = 4'd0;
      end else begin
        hl_nx_s = hl_r + 4'd1;
      end
    end else begin
      hh_nx_s = hh_r;
      hl_nx_s = hl_r;
    end
  end

  // Hour pair register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hh_r <= 4'd0;
      hl_r <= 4'd0;
    end else if (load_ok_s) begin
      hh_r <= set_time_s.hh;
      hl_r <= set_time_s.hl;
    end else begin
      hh_r <= hh_nx_s;
      hl_r <= hl_nx_s;
    end
  end

  // Minute digits as they will read after this cycle's advance (alarm compare).
  assign mh_nx_s   = c_mh_s ? 4'd0 : (c_ml_s ? (mh_s + 4'd1) : mh_s);
  assign ml_nx_s   = c_ml_s ? 4'd0 : (c_sh_s ? (ml_s + 4'd1) : ml_s);
  assign next_hm_s = '{hh: hh_nx_s, hl: hl_nx_s, mh: mh_nx_s, ml: ml_nx_s};

  // Registered strobes, aligned with the cycle the new time becomes visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_o     <= 1'b0;
      day_wrap_o <= 1'b0;
      set_err_o  <= 1'b0;
    end else begin
      tick_o     <= adv_s;
      day_wrap_o <= hour_wrap_s;
      set_err_o  <= load_bad_s;
    end
  end

  if (HAS_ALARM) begin : g_alarm
    alarm_t alarm_r;

    // Alarm time register, loaded unchecked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        alarm_r <= '0;
      end else if (alarm_set_i) begin
        alarm_r <= alarm_t'(alarm_time_i);
      end else begin
        alarm_r <= alarm_r;
      end
    end

    // Alarm fires only on an advance into HH:MM:00, against the pre-update alarm value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        alarm_o <= 1'b0;
      end else begin
        alarm_o <= alarm_en_i & c_sh_s & (alarm_r == next_hm_s);
      end
    end
  end else begin : g_no_alarm
    assign alarm_o = 1'b0;
  end

  // Display hour mapping for 12/24h mode and the PM flag.
  always_comb begin
    pm_s      = (hh_r == 4'd2) | ((hh_r == 4'd1) & (hl_r >= 4'd2));
    disp_hh_s = hh_r;
    disp_hl_s = hl_r;
    if (mode12_i) begin
      if ((hh_r == 4'd0) && (hl_r == 4'd0)) begin
        disp_hh_s = 4'd1;
        disp_hl_s = 4'd2;
      end else if ((hh_r == 4'd1) && (hl_r >= 4'd3)) begin
        disp_hh_s = 4'd0;
        disp_hl_s = hl_r - 4'd2;
      end else if ((hh_r == 4'd2) && (hl_r <= 4'd1)) begin
        disp_hh_s = 4'd0;
        disp_hl_s = hl_r + 4'd8;
      end else if (hh_r == 4'd2) begin
        disp_hh_s = 4'd1;
        disp_hl_s = hl_r - 4'd2;
      end else begin
        disp_hh_s = hh_r;
        disp_hl_s = hl_r;
      end
    end else begin
      disp_hh_s = hh_r;
      disp_hl_s = hl_r;
    end
  end

  assign pm_o           = pm_s;
  assign hours_high_o   = disp_hh_s;
  assign hours_low_o    = disp_hl_s;
  assign minutes_high_o = mh_s;
  assign minutes_low_o  = ml_s;
  assign seconds_high_o = sh_s;
  assign seconds_low_o  = sl_s;

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Scoreboard bench: two clocks (CLK_DIV 4 and 1) share stimulus; a
// seconds-of-day reference model predicts every cycle's outputs.
module tb_bcd_rtc_clock;

  typedef struct packed {
    logic [23:0] digits;
    logic        pm;
    logic        tick;
    logic        wrap;
    logic        err;
    logic        alm;
  } exp_t;

  typedef struct packed {
    int          secs;
    int          presc;
    logic [15:0] alm;
    exp_t        e;
  } mdl_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        mode12_i = 1'b0;
  logic        set_valid_i = 1'b0;
  logic [23:0] set_time_i = 24'h0;
  logic        alarm_set_i = 1'b0;
  logic [15:0] alarm_time_i = 16'h0;
  logic        alarm_en_i = 1'b0;

  logic       err4, alm4, tick4, wrap4, pm4;
  logic [3:0] hh4, hl4, mh4, ml4, sh4, sl4;
  logic       err1, alm1, tick1, wrap1, pm1;
  logic [3:0] hh1, hl1, mh1, ml1, sh1, sl1;

  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q1[$];
  mdl_t m4, m1;

  always #5 clk_i = ~clk_i;

  bcd_rtc_clock #(.CLK_DIV(4), .HAS_ALARM(1'b1)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .mode12_i(mode12_i),
    .set_valid_i(set_valid_i), .set_time_i(set_time_i), .set_err_o(err4),
    .alarm_set_i(alarm_set_i), .alarm_time_i(alarm_time_i), .alarm_en_i(alarm_en_i),
    .alarm_o(alm4), .tick_o(tick4), .day_wrap_o(wrap4), .pm_o(pm4),
    .hours_high_o(hh4), .hours_low_o(hl4), .minutes_high_o(mh4), .minutes_low_o(ml4),
    .seconds_high_o(sh4), .seconds_low_o(sl4)
  );

  bcd_rtc_clock #(.CLK_DIV(1), .HAS_ALARM(1'b1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .mode12_i(mode12_i),
    .set_valid_i(set_valid_i), .set_time_i(set_time_i), .set_err_o(err1),
    .alarm_set_i(alarm_set_i), .alarm_time_i(alarm_time_i), .alarm_en_i(alarm_en_i),
    .alarm_o(alm1), .tick_o(tick1), .day_wrap_o(wrap1), .pm_o(pm1),
    .hours_high_o(hh1), .hours_low_o(hl1), .minutes_high_o(mh1), .minutes_low_o(ml1),
    .seconds_high_o(sh1), .seconds_low_o(sl1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (seconds-of-day arithmetic) ----------------
  function automatic bit time_ok(input logic [23:0] t);
    int hh = int'(t[23:20]);
    int hl = int'(t[19:16]);
    return hh <= 2 && hl <= 9 && (hh * 10 + hl) <= 23 && t[15:12] <= 4'd5 &&
           t[11:8] <= 4'd9 && t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
  endfunction

  function automatic int to_secs(input logic [23:0] t);
    int h = int'(t[23:20]) * 10 + int'(t[19:16]);
    int m = int'(t[15:12]) * 10 + int'(t[11:8]);
    int s = int'(t[7:4]) * 10 + int'(t[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic exp_t show(input exp_t e, input int secs, input logic m12);
    exp_t r = e;
    int h = secs / 3600;
    int mi = (secs / 60) % 60;
    int s = secs % 60;
    int dh;
    dh = h;
    if (m12) begin
      dh = h % 12;
      if (dh == 0) dh = 12;
    end
    r.digits = {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    r.pm = (h >= 12);
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int div, input logic en, input logic m12,
                                input logic sv, input logic [23:0] st, input logic as,
                                input logic [15:0] at, input logic ae);
    mdl_t n = m;
    bit loaded = 1'b0;
    bit tick = 1'b0;
    logic [23:0] alarm_full;
    n.e.err = 1'b0; n.e.tick = 1'b0; n.e.wrap = 1'b0; n.e.alm = 1'b0;
    if (sv) begin
      if (time_ok(st)) begin
        loaded = 1'b1;
        n.secs = to_secs(st);
        n.presc = 0;
      end else begin
        n.e.err = 1'b1;
      end
    end
    if (!loaded && en) begin
      if (m.presc == div - 1) begin
        tick = 1'b1;
        n.presc = 0;
      end else begin
        n.presc = m.presc + 1;
      end
    end
    if (tick) begin
      n.secs = (m.secs + 1) % 86400;
      n.e.tick = 1'b1;
      n.e.wrap = (n.secs == 0);
      alarm_full = {m.alm, 8'h00};
      n.e.alm = ae && time_ok(alarm_full) && (n.secs == to_secs(alarm_full));
    end
    if (as) n.alm = at;
    n.e = show(n.e, n.secs, m12);
    return n;
  endfunction

  // ---------------- driver: apply one cycle of inputs, predict outputs ----------------
  task automatic drive(input logic en, input logic m12, input logic sv, input logic [23:0] st,
                       input logic as, input logic [15:0] at, input logic ae);
    @(negedge clk_i);
    en_i = en; mode12_i = m12; set_valid_i = sv; set_time_i = st;
    alarm_set_i = as; alarm_time_i = at; alarm_en_i = ae;
    m4 = step(m4, 4, en, m12, sv, st, as, at, ae);
    m1 = step(m1, 1, en, m12, sv, st, as, at, ae);
    q4.push_back(m4.e);
    q1.push_back(m1.e);
  endtask

  task automatic run(input int n, input logic m12, input logic ae);
    for (int i = 0; i < n; i++) drive(1'b1, m12, 1'b0, 24'h0, 1'b0, 16'h0, ae);
  endtask

  task automatic load(input logic [23:0] t, input logic en, input logic m12, input logic ae);
    drive(en, m12, 1'b1, t, 1'b0, 16'h0, ae);
  endtask

  function automatic logic [23:0] rand_time();
    if ($urandom_range(0, 3) == 0) return 24'($urandom);
    return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic cmp(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".digits"}, int'(a.digits), int'(e.digits));
    chk({tag, ".pm"}, int'(a.pm), int'(e.pm));
    chk({tag, ".tick"}, int'(a.tick), int'(e.tick));
    chk({tag, ".day_wrap"}, int'(a.wrap), int'(e.wrap));
    chk({tag, ".set_err"}, int'(a.err), int'(e.err));
    chk({tag, ".alarm"}, int'(a.alm), int'(e.alm));
  endtask

  // ---------------- monitor: pop expected and compare after each edge ----------------
  exp_t a4, a1, e4, e1;
  always @(posedge clk_i) begin
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      a4 = '{digits: {hh4, hl4, mh4, ml4, sh4, sl4}, pm: pm4, tick: tick4, wrap: wrap4,
             err: err4, alm: alm4};
      cmp("div4", e4, a4);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      a1 = '{digits: {hh1, hl1, mh1, ml1, sh1, sl1}, pm: pm1, tick: tick1, wrap: wrap1,
             err: err1, alm: alm1};
      cmp("div1", e1, a1);
    end
  end

  initial begin
    m4 = '0;
    m1 = '0;
    // Reset state in both display modes.
    #12;
    chk("rst.digits24", int'({hh4, hl4, mh4, ml4, sh4, sl4}), 32'h000000);
    chk("rst.strobes", int'({tick4, wrap4, err4, alm4, pm4}), 0);
    mode12_i = 1'b1;
    #1;
    chk("rst.digits12", int'({hh4, hl4, mh4, ml4, sh4, sl4}), 32'h120000);
    chk("rst.pm12", int'(pm4), 0);
    mode12_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 40 enabled cycles from reset.
    run(40, 1'b0, 1'b0);
    // Day rollover.
    load(24'h235958, 1'b1, 1'b0, 1'b0);
    run(8, 1'b0, 1'b0);
    // Rejected loads.
    load(24'h240000, 1'b1, 1'b0, 1'b0);
    load(24'h126000, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0);
    // Load colliding with a tick of the divide-by-4 clock.
    load(24'h000000, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0);
    load(24'h123000, 1'b1, 1'b0, 1'b0);
    run(6, 1'b0, 1'b0);
    // Alarm armed, disarmed, and reached by a load.
    drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, 16'h0700, 1'b1);
    load(24'h065959, 1'b1, 1'b0, 1'b1);
    run(5, 1'b0, 1'b1);
    load(24'h065959, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0);
    load(24'h070000, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1);
    // Alarm reload coinciding with a match uses the old value.
    load(24'h065959, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 24'h0, 1'b1, 16'h0815, 1'b1);
    // 12-hour display.
    load(24'h001500, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    load(24'h121500, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    load(24'h131500, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 16'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
            rand_time(), $urandom_range(0, 49) == 0, rand_time()[23:8],
            $urandom_range(0, 3) != 0);
    end

    run(2, 1'b0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("queue_drained", q4.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
